// File: rtl/boe_frame_sequencer.sv
// Upstream timing master for BOE: ping-pong frame buffering, filler insertion and result tagging.
// Optional BOE_SEQ_EXP_EN adds per-frame expected max/sum outputs for scoreboarding.
module boe_frame_sequencer #(
  parameter int unsigned DW     = 8,
  parameter int unsigned MAX_N  = 6,
  parameter int unsigned FILL_N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [2:0]    s_num,
  output logic          err,
  output logic [2:0]    data_num,
  output logic [DW-1:0] data_in,
  output logic          frame_start,
  output logic [1:0]    res_tag,
  output logic          res_real
`ifdef BOE_SEQ_EXP_EN
  ,
  output logic [DW-1:0] exp_max,
  output logic [10:0]   exp_sum
`endif
);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkFeeding} bank_st_e;

  localparam logic [2:0] MaxN      = 3'(MAX_N);
  localparam logic [2:0] FillN     = 3'(FILL_N);
  localparam logic [1:0] TagNone   = 2'd0;
  localparam logic [1:0] TagMax    = 2'd1;
  localparam logic [1:0] TagSum    = 2'd2;
  localparam logic [1:0] TagSorted = 2'd3;

  bank_st_e      bank_st_q   [2];
  bank_st_e      bank_st_d   [2];
  logic [2:0]    bank_num_q  [2];
  logic [2:0]    bank_num_d  [2];
  logic [DW-1:0] bank_data_q [2][MAX_N];
  logic [DW-1:0] bank_data_d [2][MAX_N];
  logic          fill_ptr_q, fill_ptr_d, feed_ptr_q, feed_ptr_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [2:0]    cur_n_q, cur_n_d;
  logic          cur_real_q, cur_real_d, cur_bank_q, cur_bank_d;
  logic          prev_valid_q, prev_valid_d, prev_real_q, prev_real_d;
  logic          err_q, err_d;
`ifdef BOE_SEQ_EXP_EN
  logic [DW-1:0] bank_max_q [2];
  logic [DW-1:0] bank_max_d [2];
  logic [10:0]   bank_sum_q [2];
  logic [10:0]   bank_sum_d [2];
`endif

  logic       accept, legal, frame_end, feeding;
  logic [3:0] n4;

  assign s_ready   = (bank_st_q[fill_ptr_q] == BkEmpty) || (bank_st_q[fill_ptr_q] == BkFilling);
  assign accept    = s_valid && s_ready;
  assign legal     = (s_num >= 3'd2) && (s_num <= MaxN);
  assign n4        = {1'b0, cur_n_q};
  assign frame_end = (cyc_q == {cur_n_q, 1'b1});

  always_comb begin
    bank_st_d    = bank_st_q;
    bank_num_d   = bank_num_q;
    bank_data_d  = bank_data_q;
    fill_ptr_d   = fill_ptr_q;
    feed_ptr_d   = feed_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    cyc_d        = cyc_q + 4'd1;
    cur_n_d      = cur_n_q;
    cur_real_d   = cur_real_q;
    cur_bank_d   = cur_bank_q;
    prev_valid_d = prev_valid_q;
    prev_real_d  = prev_real_q;
    err_d        = 1'b0;
`ifdef BOE_SEQ_EXP_EN
    bank_max_d   = bank_max_q;
    bank_sum_d   = bank_sum_q;
`endif
    if (accept) begin
      if (beat_cnt_q == 3'd0) begin
        if (legal) begin
          bank_st_d[fill_ptr_q]      = BkFilling;
          bank_num_d[fill_ptr_q]     = s_num;
          bank_data_d[fill_ptr_q][0] = s_data;
          beat_cnt_d                 = 3'd1;
`ifdef BOE_SEQ_EXP_EN
          bank_max_d[fill_ptr_q]     = s_data;
          bank_sum_d[fill_ptr_q]     = 11'(s_data);
`endif
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bank_data_d[fill_ptr_q][beat_cnt_q] = s_data;
`ifdef BOE_SEQ_EXP_EN
        if (s_data > bank_max_q[fill_ptr_q]) bank_max_d[fill_ptr_q] = s_data;
        bank_sum_d[fill_ptr_q] = bank_sum_q[fill_ptr_q] + 11'(s_data);
`endif
        if (beat_cnt_q == bank_num_q[fill_ptr_q] - 3'd1) begin
          bank_st_d[fill_ptr_q] = BkFull;
          beat_cnt_d            = 3'd0;
          fill_ptr_d            = ~fill_ptr_q;
        end else begin
          beat_cnt_d = beat_cnt_q + 3'd1;
        end
      end
    end
    // Selection sees a bank completed by a beat on this same edge.
    if (frame_end) begin
      cyc_d        = 4'd0;
      prev_valid_d = 1'b1;
      prev_real_d  = cur_real_q;
      if (cur_real_q) bank_st_d[cur_bank_q] = BkEmpty;
      if (bank_st_d[feed_ptr_q] == BkFull) begin
        cur_real_d            = 1'b1;
        cur_bank_d            = feed_ptr_q;
        cur_n_d               = bank_num_d[feed_ptr_q];
        bank_st_d[feed_ptr_q] = BkFeeding;
        feed_ptr_d            = ~feed_ptr_q;
      end else begin
        cur_real_d = 1'b0;
        cur_n_d    = FillN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]  <= BkEmpty;
        bank_num_q[b] <= 3'd0;
        for (int i = 0; i < int'(MAX_N); i++) bank_data_q[b][i] <= '0;
`ifdef BOE_SEQ_EXP_EN
        bank_max_q[b] <= '0;
        bank_sum_q[b] <= '0;
`endif
      end
      fill_ptr_q   <= 1'b0;
      feed_ptr_q   <= 1'b0;
      beat_cnt_q   <= 3'd0;
      cyc_q        <= 4'd0;
      cur_n_q      <= FillN;
      cur_real_q   <= 1'b0;
      cur_bank_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_real_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      bank_num_q   <= bank_num_d;
      bank_data_q  <= bank_data_d;
`ifdef BOE_SEQ_EXP_EN
      bank_max_q   <= bank_max_d;
      bank_sum_q   <= bank_sum_d;
`endif
      fill_ptr_q   <= fill_ptr_d;
      feed_ptr_q   <= feed_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      cyc_q        <= cyc_d;
      cur_n_q      <= cur_n_d;
      cur_real_q   <= cur_real_d;
      cur_bank_q   <= cur_bank_d;
      prev_valid_q <= prev_valid_d;
      prev_real_q  <= prev_real_d;
      err_q        <= err_d;
    end
  end

  assign feeding     = (cyc_q < n4);
  assign data_num    = feeding ? cur_n_q : 3'd0;
  assign data_in     = (feeding && cur_real_q) ? bank_data_q[cur_bank_q][cyc_q[2:0]] : '0;
  assign frame_start = (cyc_q == 4'd0);
  assign err         = err_q;

  // BOE registers its result, so the last sorted entry spills into the next frame's cycle 0.
  always_comb begin
    res_tag  = TagNone;
    res_real = 1'b0;
    if (cyc_q == 4'd0) begin
      if (prev_valid_q) begin
        res_tag  = TagSorted;
        res_real = prev_real_q;
      end
    end else if (cyc_q == n4 + 4'd1) begin
      res_tag  = TagMax;
      res_real = cur_real_q;
    end else if (cyc_q == n4 + 4'd2) begin
      res_tag  = TagSum;
      res_real = cur_real_q;
    end else if (cyc_q >= n4 + 4'd3) begin
      res_tag  = TagSorted;
      res_real = cur_real_q;
    end
  end

`ifdef BOE_SEQ_EXP_EN
  assign exp_max = (res_tag == TagMax && res_real) ? bank_max_q[cur_bank_q] : '0;
  assign exp_sum = (res_tag == TagSum && res_real) ? bank_sum_q[cur_bank_q] : '0;
`endif

endmodule
